pc_branch_unit: RTL

- Parametrised successor to the CPU's PC/branch control block.
- Owns the ZVN flag register. Predicts B-type branches at fetch with a 2-bit-counter branch history table (BHT). Resolves B and BR in EX and raises a same-cycle redirect on mispredict.
- Keeps saturating branch and mispredict counters for performance debug.
- Sits between the fetch PC mux and the EX stage of the 16-bit pipeline.

---
 rtl/pc_branch_unit.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/pc_branch_unit.sv
// ---------------------------------------------------------------------------
// pc_branch_unit
//
// PC / branch control block for the 16-bit pipeline. It owns the {Z,V,N}
// flag register. A 2-bit-counter branch history table (BHT) predicts B-type
// branches at fetch. B and BR branches are resolved in EX, and a
// same-cycle redirect is raised on a mispredict. Two saturating
// performance counters record resolved branches and mispredicts.
//
// Parameters
//   ADDR_W     PC / register width (10 or more)
//   BHT_IDX_W  BHT index bits; the table holds 2**BHT_IDX_W entries
//   CNT_W      width of each performance counter
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   f_valid         fetch slot holds a valid instruction
//   f_pc, f_instr   fetched PC and instruction
//   f_pred_taken    fetch predicts taken (combinational)
//   f_pc_next       predicted next PC (combinational)
//   x_valid         EX slot holds a valid instruction
//   x_pc, x_instr   EX PC and instruction
//   x_pred_taken    prediction carried down with the EX instruction
//   x_rs_val        register target for BR
//   flags_in        ALU result flags {Z,V,N}
//   flags_we        per-flag write enable {Z,V,N}, qualified by x_valid
//   flags           registered flags {Z,V,N}
//   x_taken         resolved outcome of the EX branch (combinational)
//   redirect        mispredict; fetch must load redirect_pc (combinational)
//   redirect_pc     corrected PC (combinational)
//   br_count        resolved-branch counter (registered, saturating)
//   mispred_count   mispredict counter (registered, saturating)
// ---------------------------------------------------------------------------
module pc_branch_unit #(
    parameter int ADDR_W    = 16,
    parameter int BHT_IDX_W = 4,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_valid,
    input  logic [ADDR_W-1:0] f_pc,
    input  logic [15:0]       f_instr,
    output logic              f_pred_taken,
    output logic [ADDR_W-1:0] f_pc_next,
    input  logic              x_valid,
    input  logic [ADDR_W-1:0] x_pc,
    input  logic [15:0]       x_instr,
    input  logic              x_pred_taken,
    input  logic [ADDR_W-1:0] x_rs_val,
    input  logic [2:0]        flags_in,
    input  logic [2:0]        flags_we,
    output logic [2:0]        flags,
    output logic              x_taken,
    output logic              redirect,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic [CNT_W-1:0]  br_count,
    output logic [CNT_W-1:0]  mispred_count
);

    localparam int BHT_N = 1 << BHT_IDX_W;

    localparam logic [3:0] OP_B   = 4'b1100;
    localparam logic [3:0] OP_BR  = 4'b1101;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam logic [ADDR_W-1:0] PC_STEP     = ADDR_W'(2);
    localparam logic [1:0]        BHT_INIT    = 2'b01;
    localparam logic [1:0]        BHT_MAX     = 2'b11;
    localparam logic [1:0]        BHT_MIN     = 2'b00;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // B target: pc + 2 + (sign-extended imm << 1), modulo 2**ADDR_W.
    function automatic logic [ADDR_W-1:0] b_target(
        input logic [ADDR_W-1:0] pc,
        input logic [8:0]        imm
    );
        logic [ADDR_W-1:0] off;
        off = {{(ADDR_W-9){imm[8]}}, imm};
        return pc + PC_STEP + {off[ADDR_W-2:0], 1'b0};
    endfunction

    // Branch condition on the effective {Z,V,N}.
    function automatic logic cond_met(
        input logic [2:0] c,
        input logic       z,
        input logic       v,
        input logic       n
    );
        logic r;
        case (c)
            3'b000:  r = ~z;
            3'b001:  r = z;
            3'b010:  r = ~z & ~n;
            3'b011:  r = n;
            3'b100:  r = z | (~z & ~n);
            3'b101:  r = z | n;
            3'b110:  r = v;
            3'b111:  r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // 2-bit saturating counter step.
    function automatic logic [1:0] bht_step(
        input logic [1:0] ctr,
        input logic       taken
    );
        logic [1:0] r;
        if (taken) begin
            r = (ctr == BHT_MAX) ? ctr : ctr + 2'b01;
        end else begin
            r = (ctr == BHT_MIN) ? ctr : ctr - 2'b01;
        end
        return r;
    endfunction

    // Performance counter increment, holding at all-ones.
    function automatic logic [CNT_W-1:0] cnt_sat_inc(
        input logic [CNT_W-1:0] c
    );
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]                  flags_q,   flags_d;
    logic [BHT_N-1:0][1:0]       bht_q,     bht_d;
    logic [CNT_W-1:0]            br_cnt_q,  br_cnt_d;
    logic [CNT_W-1:0]            mis_cnt_q, mis_cnt_d;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [3:0]           f_op;
    logic [3:0]           x_op;
    logic                 x_is_b;
    logic                 x_is_branch;
    logic [BHT_IDX_W-1:0] f_idx;
    logic [BHT_IDX_W-1:0] x_idx;
    logic [2:0]           eff_flags;
    logic [2:0]           we_mask;

    assign f_op        = f_instr[15:12];
    assign x_op        = x_instr[15:12];
    assign x_is_b      = (x_op == OP_B);
    assign x_is_branch = (x_op == OP_B) | (x_op == OP_BR);
    assign f_idx       = f_pc[BHT_IDX_W:1];
    assign x_idx       = x_pc[BHT_IDX_W:1];

    // Same-cycle bypass: flags written by the EX instruction are used by
    // its own branch condition.
    assign we_mask   = x_valid ? flags_we : 3'b000;
    assign eff_flags = (flags_in & we_mask) | (flags_q & ~we_mask);

    // Fetch-side prediction and next-PC selection.
    always_comb begin
        f_pred_taken = 1'b0;
        f_pc_next    = f_pc + PC_STEP;
        if (f_valid && (f_op == OP_B)) begin
            f_pred_taken = bht_q[f_idx][1];
        end else begin
            f_pred_taken = 1'b0;
        end
        if (f_valid && (f_op == OP_HLT)) begin
            f_pc_next = f_pc;
        end else if (f_pred_taken) begin
            f_pc_next = b_target(f_pc, f_instr[8:0]);
        end else begin
            f_pc_next = f_pc + PC_STEP;
        end
    end

    // EX-side resolution and redirect generation.
    always_comb begin
        x_taken     = 1'b0;
        redirect    = 1'b0;
        redirect_pc = x_pc + PC_STEP;
        if (x_valid && x_is_branch) begin
            x_taken  = cond_met(x_instr[11:9], eff_flags[2], eff_flags[1],
                                eff_flags[0]);
            redirect = x_taken ^ x_pred_taken;
        end else begin
            x_taken  = 1'b0;
            redirect = 1'b0;
        end
        if (x_taken) begin
            redirect_pc = x_is_b ? b_target(x_pc, x_instr[8:0]) : x_rs_val;
        end else begin
            redirect_pc = x_pc + PC_STEP;
        end
    end

    // Next-state for flags, BHT and performance counters.
    always_comb begin
        flags_d   = eff_flags;
        bht_d     = bht_q;
        br_cnt_d  = br_cnt_q;
        mis_cnt_d = mis_cnt_q;
        // Fetch reads bht_q directly, so a same-entry update this cycle is
        // only visible to fetch from the next cycle on.
        if (x_valid && x_is_b) begin
            bht_d[x_idx] = bht_step(bht_q[x_idx], x_taken);
        end else begin
            bht_d = bht_q;
        end
        if (x_valid && x_is_branch) begin
            br_cnt_d = cnt_sat_inc(br_cnt_q);
        end else begin
            br_cnt_d = br_cnt_q;
        end
        if (redirect) begin
            mis_cnt_d = cnt_sat_inc(mis_cnt_q);
        end else begin
            mis_cnt_d = mis_cnt_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q   <= 3'b000;
            bht_q     <= {BHT_N{BHT_INIT}};
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            flags_q   <= flags_d;
            bht_q     <= bht_d;
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    assign flags         = flags_q;
    assign br_count      = br_cnt_q;
    assign mispred_count = mis_cnt_q;

endmodule
